game_state_manager: RTL and testbench
=====================================

GAME_STATE_MANAGER -- requirements
Module: game_state_manager

Interface
REQ-001 Parameter LIFE_W, default 4, life counter width.
REQ-002 Parameter SCORE_W, default 10, score counter width.
REQ-003 Parameter INIT_LIFE, default 3, life loaded at reset and at game start.
REQ-004 Parameter MAX_LIFE, default 9, life saturation ceiling.
REQ-005 Parameter SPAWN_PERIOD, default 64, frames between spawn decisions.
REQ-006 Parameter INVULN_FRAMES, default 30, frames of invulnerability after a bad collision.
REQ-007 Parameter LIFE_THRESH, default 32, and COIN_THRESH, default 128, spawn-type thresholds on random_number.
REQ-008 clk  in  1  system clock; the block has one clock.
REQ-009 resetN  in  1  reset, synchronous and active-low.
REQ-010 hit_type  in  3  0 none, 1 life, 2 coin, 3 good collision, 4 bad collision; valid every cycle.
REQ-011 random_number  in  8  pseudo-random value.
REQ-012 start_of_frame  in  1  one-cycle pulse per video frame.
REQ-013 start_game  in  1  one-cycle start/restart request.
REQ-014 spawn_ack  in  1  consumer accepted the pending spawn.
REQ-015 life_counter  out  LIFE_W  remaining lives.
REQ-016 score_counter  out  SCORE_W  current score.
REQ-017 game_state  out  2  0 IDLE, 1 PLAY, 2 HIT_PAUSE, 3 GAME_OVER.
REQ-018 spawn_valid  out  1  spawn request pending.
REQ-019 what_to_create  out  3  object to spawn: 1 life, 2 coin, 4 obstacle.
REQ-020 sound  out  1  one-cycle pulse per accepted hit.

Function
REQ-021 IDLE: hits are ignored; start_game loads INIT_LIFE, clears score and frame counter, and moves to PLAY next cycle.
REQ-022 PLAY/HIT_PAUSE: life hit increments life, saturating at MAX_LIFE; coin adds 1 and good collision adds 2 to score, saturating at 2^SCORE_W-1.
REQ-023 PLAY: a bad collision decrements life; a resulting life of 0 enters GAME_OVER, otherwise HIT_PAUSE with the invulnerability counter loaded to INVULN_FRAMES.
REQ-024 HIT_PAUSE: bad collisions are ignored; each start_of_frame decrements the invulnerability counter; on reaching 0 the state returns to PLAY.
REQ-025 GAME_OVER: hits ignored, spawn_valid cleared, counters frozen; start_game behaves as in REQ-021.
REQ-026 Frame counter counts start_of_frame only in PLAY/HIT_PAUSE, wrapping at SPAWN_PERIOD-1 to 0.
REQ-027 On wrap with spawn_valid low: spawn_valid rises next cycle; what_to_create is 1 if random_number<LIFE_THRESH, 2 if <COIN_THRESH, else 4, latched at that cycle.
REQ-028 spawn_valid and what_to_create hold until a cycle with spawn_ack high, then spawn_valid clears next cycle; spawn_ack with spawn_valid low is ignored.
REQ-029 A wrap while spawn_valid is high is dropped; no queueing.
REQ-030 sound pulses for exactly one cycle after any hit that changes a counter or state; ignored and saturated-no-change hits give no pulse.
REQ-031 start_game in PLAY/HIT_PAUSE restarts as in REQ-021 and clears spawn_valid; it takes priority over a same-cycle hit.
REQ-032 A same-cycle start_of_frame and hit are both applied.

Reset
REQ-033 When resetN is low at a clk edge: state IDLE, life_counter=INIT_LIFE, score_counter=0, spawn_valid=0, what_to_create=0, sound=0, frame and invulnerability counters 0.
REQ-034 A mid-game reset discards any pending spawn and the invulnerability time without further output activity.

Configuration
REQ-035 With macro BONUS_LIFE_EN defined, a score increment crossing a multiple of 100 also increments life, saturating at MAX_LIFE, in the same cycle; without it, score never affects life; ports are identical in both builds.

Verification
REQ-036 Reset, start_game, 3 coin hits, 1 good hit -> state PLAY, score 5, life 3, 4 sound pulses.
REQ-037 Bad hit in PLAY, then bad hit during HIT_PAUSE -> life 2 after the first hit, second ignored, PLAY after 30 frames.
REQ-038 Life 1 plus bad hit -> life 0, GAME_OVER, spawn_valid 0; start_game -> life 3, score 0, PLAY.
REQ-039 SPAWN_PERIOD=4, random_number 10/200 at successive wraps, ack each -> what_to_create 1 then 4; a withheld ack drops the next wrap.
REQ-040 Life 9 plus life hit -> life stays 9, no sound; score 1023 plus coin -> score 1023.
REQ-041 BONUS_LIFE_EN, score 99 plus good hit -> score 101, life +1; without macro, life unchanged.

Source files
------------

// File: rtl/game_state_manager_if.sv
// Bundled game-logic signals between the game state manager and its
// environment. The master drives hits, frame timing, start and spawn
// acknowledge. The slave returns the game status and spawn requests.
interface game_state_manager_if #(
  parameter int LIFE_W  = 4,
  parameter int SCORE_W = 10
);
  logic [2:0]         hit_type;
  logic [7:0]         random_number;
  logic               start_of_frame;
  logic               start_game;
  logic               spawn_ack;
  logic [LIFE_W-1:0]  life_counter;
  logic [SCORE_W-1:0] score_counter;
  logic [1:0]         game_state;
  logic               spawn_valid;
  logic [2:0]         what_to_create;
  logic               sound;

  modport master (
    output hit_type, random_number, start_of_frame, start_game, spawn_ack,
    input  life_counter, score_counter, game_state, spawn_valid,
           what_to_create, sound
  );

  modport slave (
    input  hit_type, random_number, start_of_frame, start_game, spawn_ack,
    output life_counter, score_counter, game_state, spawn_valid,
           what_to_create, sound
  );
endinterface

// File: rtl/game_state_manager.sv
// Game state manager: tracks lives, score, invulnerability and timed spawn requests.
// Optional macro BONUS_LIFE_EN: each score crossing of a multiple of 100 also grants a life.
module game_state_manager #(
  parameter int LIFE_W        = 4,
  parameter int SCORE_W       = 10,
  parameter int INIT_LIFE     = 3,
  parameter int MAX_LIFE      = 9,
  parameter int SPAWN_PERIOD  = 64,
  parameter int INVULN_FRAMES = 30,
  parameter int LIFE_THRESH   = 32,
  parameter int COIN_THRESH   = 128
) (
  input  logic                 clk,
  input  logic                 resetN,
  game_state_manager_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_HIT_PAUSE = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  localparam int FRAME_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int INV_W   = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  localparam logic [LIFE_W-1:0]  INIT_LIFE_V = LIFE_W'(INIT_LIFE);
  localparam logic [LIFE_W-1:0]  MAX_LIFE_V  = LIFE_W'(MAX_LIFE);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
  localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(SPAWN_PERIOD - 1);
  localparam logic [INV_W-1:0]   INV_LOAD    = INV_W'(INVULN_FRAMES);

  state_t             state_q, state_d;
  logic [LIFE_W-1:0]  life_q, life_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [INV_W-1:0]   inv_q, inv_d;
  logic               spawn_valid_q, spawn_valid_d;
  logic [2:0]         wtc_q, wtc_d;
  logic               sound_q, sound_d;

  logic               active;
  logic               wrap;
  logic [SCORE_W-1:0] score_new;

  function automatic logic [SCORE_W-1:0] sat_score_add(input logic [SCORE_W-1:0] s,
                                                       input logic [1:0] inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + {{(SCORE_W-1){1'b0}}, inc};
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

  function automatic logic [LIFE_W-1:0] sat_life_inc(input logic [LIFE_W-1:0] l);
    return (l >= MAX_LIFE_V) ? l : l + LIFE_W'(1);
  endfunction

  function automatic logic [2:0] classify(input logic [7:0] r);
    if (int'(r) < LIFE_THRESH)      return 3'd1;
    else if (int'(r) < COIN_THRESH) return 3'd2;
    else                            return 3'd4;
  endfunction

`ifdef BONUS_LIFE_EN
  function automatic logic crosses_hundred(input logic [SCORE_W-1:0] old_s,
                                           input logic [SCORE_W-1:0] new_s);
    return (int'(old_s) / 100) != (int'(new_s) / 100);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      life_q        <= INIT_LIFE_V;
      score_q       <= '0;
      frame_q       <= '0;
      inv_q         <= '0;
      spawn_valid_q <= 1'b0;
      wtc_q         <= '0;
      sound_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      life_q        <= life_d;
      score_q       <= score_d;
      frame_q       <= frame_d;
      inv_q         <= inv_d;
      spawn_valid_q <= spawn_valid_d;
      wtc_q         <= wtc_d;
      sound_q       <= sound_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    life_d        = life_q;
    score_d       = score_q;
    frame_d       = frame_q;
    inv_d         = inv_q;
    spawn_valid_d = spawn_valid_q;
    wtc_d         = wtc_q;
    sound_d       = 1'b0;
    wrap          = 1'b0;
    score_new     = score_q;
    active        = (state_q == S_PLAY) || (state_q == S_HIT_PAUSE);

    // start_game outranks any same-cycle hit, in every state
    if (bus.start_game) begin
      state_d       = S_PLAY;
      life_d        = INIT_LIFE_V;
      score_d       = '0;
      frame_d       = '0;
      inv_d         = '0;
      spawn_valid_d = 1'b0;
    end else if (active) begin
      if (bus.start_of_frame) begin
        wrap    = (frame_q == FRAME_LAST);
        frame_d = wrap ? '0 : frame_q + FRAME_W'(1);
      end

      // a wrap while a request is still pending is dropped
      if (spawn_valid_q) begin
        spawn_valid_d = !bus.spawn_ack;
      end else if (wrap) begin
        spawn_valid_d = 1'b1;
        wtc_d         = classify(bus.random_number);
      end

      if ((state_q == S_HIT_PAUSE) && bus.start_of_frame) begin
        inv_d = inv_q - INV_W'(1);
        if (inv_q <= INV_W'(1)) state_d = S_PLAY;
      end

      case (bus.hit_type)
        3'd1: begin
          if (life_q < MAX_LIFE_V) begin
            life_d  = sat_life_inc(life_q);
            sound_d = 1'b1;
          end
        end
        3'd2, 3'd3: begin
          score_new = sat_score_add(score_q, (bus.hit_type == 3'd3) ? 2'd2 : 2'd1);
          if (score_new != score_q) begin
            score_d = score_new;
            sound_d = 1'b1;
`ifdef BONUS_LIFE_EN
            if (crosses_hundred(score_q, score_new)) life_d = sat_life_inc(life_q);
`endif
          end
        end
        3'd4: begin
          if (state_q == S_PLAY) begin
            sound_d = 1'b1;
            if (life_q <= LIFE_W'(1)) begin
              life_d        = '0;
              state_d       = S_GAME_OVER;
              spawn_valid_d = 1'b0;
            end else begin
              life_d  = life_q - LIFE_W'(1);
              state_d = S_HIT_PAUSE;
              inv_d   = INV_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.game_state     = state_q;
    bus.life_counter   = life_q;
    bus.score_counter  = score_q;
    bus.spawn_valid    = spawn_valid_q;
    bus.what_to_create = wtc_q;
    bus.sound          = sound_q;
  end

endmodule

// File: tb/tb_game_state_manager.sv
// Directed scenarios followed by randomized play, checked cycle by cycle
// against a rule-level model of the game state manager.
module tb_game_state_manager;

  localparam int LIFE_W        = 4;
  localparam int SCORE_W       = 10;
  localparam int INIT_LIFE     = 3;
  localparam int MAX_LIFE      = 9;
  localparam int SPAWN_PERIOD  = 4;
  localparam int INVULN_FRAMES = 30;
  localparam int LIFE_THRESH   = 32;
  localparam int COIN_THRESH   = 128;
  localparam int SCORE_CAP     = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic resetN;

  always #5 clk = ~clk;

  game_state_manager_if #(.LIFE_W(LIFE_W), .SCORE_W(SCORE_W)) bus ();

  game_state_manager #(
    .LIFE_W(LIFE_W), .SCORE_W(SCORE_W), .INIT_LIFE(INIT_LIFE), .MAX_LIFE(MAX_LIFE),
    .SPAWN_PERIOD(SPAWN_PERIOD), .INVULN_FRAMES(INVULN_FRAMES),
    .LIFE_THRESH(LIFE_THRESH), .COIN_THRESH(COIN_THRESH)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );

  // Reference model: 0 IDLE, 1 PLAY, 2 HIT_PAUSE, 3 GAME_OVER
  int m_state, m_life, m_score, m_frame, m_inv, m_wtc;
  bit m_sv, m_sound;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sound_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("game_state",     {30'd0, bus.game_state},     m_state);
    check("life_counter",   {28'd0, bus.life_counter},   m_life);
    check("score_counter",  {22'd0, bus.score_counter},  m_score);
    check("spawn_valid",    {31'd0, bus.spawn_valid},    {31'd0, m_sv});
    check("what_to_create", {29'd0, bus.what_to_create}, m_wtc);
    check("sound",          {31'd0, bus.sound},          {31'd0, m_sound});
  endtask

  task automatic model_step(input bit rstn, input int hit, input int rnd,
                            input bit sof, input bit sg, input bit ack);
    int  prev_state;
    bit  prev_sv;
    bit  wrapped;
    int  new_score;
    if (!rstn) begin
      m_state = 0; m_life = INIT_LIFE; m_score = 0; m_frame = 0;
      m_inv = 0; m_sv = 0; m_wtc = 0; m_sound = 0;
      return;
    end
    m_sound = 0;
    if (sg) begin
      m_state = 1; m_life = INIT_LIFE; m_score = 0; m_frame = 0; m_inv = 0; m_sv = 0;
      return;
    end
    if (m_state == 0 || m_state == 3) return;
    prev_state = m_state;
    prev_sv    = m_sv;
    wrapped    = 0;
    if (sof) begin
      m_frame = (m_frame + 1) % SPAWN_PERIOD;
      wrapped = (m_frame == 0);
    end
    if (prev_sv) m_sv = !ack;
    else if (wrapped) begin
      m_sv  = 1;
      m_wtc = (rnd < LIFE_THRESH) ? 1 : (rnd < COIN_THRESH) ? 2 : 4;
    end
    if (prev_state == 2 && sof) begin
      m_inv = m_inv - 1;
      if (m_inv == 0) m_state = 1;
    end
    if (hit == 1 && m_life < MAX_LIFE) begin
      m_life++;
      m_sound = 1;
    end
    if (hit == 2 || hit == 3) begin
      new_score = m_score + ((hit == 3) ? 2 : 1);
      if (new_score > SCORE_CAP) new_score = SCORE_CAP;
      if (new_score != m_score) begin
`ifdef BONUS_LIFE_EN
        if ((new_score / 100) != (m_score / 100) && m_life < MAX_LIFE) m_life++;
`endif
        m_score = new_score;
        m_sound = 1;
      end
    end
    if (hit == 4 && prev_state == 1) begin
      m_life--;
      m_sound = 1;
      if (m_life == 0) begin
        m_state = 3;
        m_sv    = 0;
      end else begin
        m_state = 2;
        m_inv   = INVULN_FRAMES;
      end
    end
  endtask

  task automatic step(input int hit, input int rnd, input bit sof,
                      input bit sg, input bit ack, input bit rstn);
    bus.hit_type       = 3'(hit);
    bus.random_number  = 8'(rnd);
    bus.start_of_frame = sof;
    bus.start_game     = sg;
    bus.spawn_ack      = ack;
    resetN             = rstn;
    @(posedge clk);
    model_step(rstn, hit, rnd, sof, sg, ack);
    #1;
    if (bus.sound === 1'b1) n_sound_pulses++;
    check_all();
  endtask

  task automatic hit(input int h);
    step(h, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic start();
    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic frames(input int n, input int rnd);
    for (int i = 0; i < n; i++) step(0, rnd, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.hit_type = '0; bus.random_number = '0; bus.start_of_frame = 1'b0;
    bus.start_game = 1'b0; bus.spawn_ack = 1'b0; resetN = 1'b0;

    // reset state
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("reset_state", {30'd0, bus.game_state}, 0);
    check("reset_life",  {28'd0, bus.life_counter}, INIT_LIFE);

    // hits in IDLE are ignored
    hit(2); hit(4);
    check("idle_score", {22'd0, bus.score_counter}, 0);

    // start, 3 coins, 1 good hit
    start();
    n_sound_pulses = 0;
    hit(2); hit(2); hit(2); hit(3); hit(0);
    check("play_state",  {30'd0, bus.game_state}, 1);
    check("play_score",  {22'd0, bus.score_counter}, 5);
    check("play_life",   {28'd0, bus.life_counter}, 3);
    check("sound_count", n_sound_pulses, 4);

    // bad hit, ignored bad hit during pause, recovery after 30 frames
    hit(4);
    check("bad_life",  {28'd0, bus.life_counter}, 2);
    check("bad_state", {30'd0, bus.game_state}, 2);
    hit(4);
    check("pause_bad_ignored", {28'd0, bus.life_counter}, 2);
    check("pause_bad_no_sound", {31'd0, bus.sound}, 0);
    frames(INVULN_FRAMES - 1, 50);
    check("still_paused", {30'd0, bus.game_state}, 2);
    frames(1, 50);
    check("pause_over", {30'd0, bus.game_state}, 1);

    // life saturation
    for (int i = 0; i < 7; i++) hit(1);
    check("life_max", {28'd0, bus.life_counter}, 9);
    hit(1);
    check("life_sat", {28'd0, bus.life_counter}, 9);
    check("life_sat_no_sound", {31'd0, bus.sound}, 0);

    // run out of lives, then restart
    start();
    hit(4); frames(INVULN_FRAMES, 200);
    hit(4); frames(INVULN_FRAMES, 200);
    hit(4);
    check("over_life",  {28'd0, bus.life_counter}, 0);
    check("over_state", {30'd0, bus.game_state}, 3);
    check("over_spawn", {31'd0, bus.spawn_valid}, 0);
    hit(2);
    check("over_frozen", {22'd0, bus.score_counter}, 0);
    start();
    check("restart_life",  {28'd0, bus.life_counter}, 3);
    check("restart_score", {22'd0, bus.score_counter}, 0);
    check("restart_state", {30'd0, bus.game_state}, 1);

    // spawn sequencing
    frames(SPAWN_PERIOD, 10);
    check("spawn1_valid", {31'd0, bus.spawn_valid}, 1);
    check("spawn1_type",  {29'd0, bus.what_to_create}, 1);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("spawn1_ack", {31'd0, bus.spawn_valid}, 0);
    frames(SPAWN_PERIOD, 200);
    check("spawn2_type", {29'd0, bus.what_to_create}, 4);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    frames(SPAWN_PERIOD, 200);
    frames(SPAWN_PERIOD, 10);
    check("spawn_drop_valid", {31'd0, bus.spawn_valid}, 1);
    check("spawn_drop_type",  {29'd0, bus.what_to_create}, 4);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("spawn3_ack", {31'd0, bus.spawn_valid}, 0);

    // score saturation
    start();
    for (int i = 0; i < 512; i++) hit(3);
    check("score_max", {22'd0, bus.score_counter}, SCORE_CAP);
    hit(2);
    check("score_sat", {22'd0, bus.score_counter}, SCORE_CAP);
    check("score_sat_no_sound", {31'd0, bus.sound}, 0);

    // crossing 100
    start();
    for (int i = 0; i < 49; i++) hit(3);
    hit(2);
    check("score_99", {22'd0, bus.score_counter}, 99);
    hit(3);
    check("score_101", {22'd0, bus.score_counter}, 101);
`ifdef BONUS_LIFE_EN
    check("bonus_life", {28'd0, bus.life_counter}, INIT_LIFE + 1);
`else
    check("bonus_life", {28'd0, bus.life_counter}, INIT_LIFE);
`endif

    // mid-game reset discards pending spawn and pause
    frames(SPAWN_PERIOD, 100);
    hit(4);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midreset_state", {30'd0, bus.game_state}, 0);
    check("midreset_spawn", {31'd0, bus.spawn_valid}, 0);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      int  h;
      bit  sof, sg, ack, rstn;
      h    = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 4));
      sof  = ($urandom_range(0, 2) == 0);
      sg   = ($urandom_range(0, 149) == 0);
      ack  = ($urandom_range(0, 3) == 0);
      rstn = ($urandom_range(0, 799) != 0);
      step(h, int'($urandom_range(0, 255)), sof, sg, ack, rstn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
